lcd_timing_gen: RTL

Raster timing generator for the 800x480 RGB LCD path. Produces the free-running `PixelCount`/`LineCount` coordinates that every pixel-painting block (title, clock digits, backgrounds) decodes. It also produces `LCD_DE`, `LCD_HSYNC` and `LCD_VSYNC` for the panel, delayed to line up with those blocks' one-cycle registered RGB outputs, plus a frame-start strobe and a frame counter for blink/animation logic.

---
 rtl/lcd_timing_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the 800x480 RGB LCD path.
// Free-running pixel/line coordinates drive the pixel-painting blocks. DE,
// HSYNC and VSYNC are decoded from those coordinates and delayed PIPE_DLY
// cycles so they line up with the painters' registered RGB. A frame-start
// strobe and a frame counter are provided for blink/animation logic.
module lcd_timing_gen #(
  parameter int H_SYNC   = 20,
  parameter int H_BACK   = 26,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 210,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 20,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 22,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic        PixelClk,
  input  logic        nRST,
  output logic [15:0] PixelCount,
  output logic [15:0] LineCount,
  output logic        LCD_DE,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        FrameStart,
  output logic [7:0]  FrameCount
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // 16-bit compare constants derived from the timing set.
  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
  localparam logic [15:0] H_DE_BEG   = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] H_DE_END   = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [15:0] V_DE_BEG   = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_DE_END   = 16'(V_SYNC + V_BACK + V_ACTIVE);

  // Refuse to elaborate with a timing set that overflows the 16-bit counts
  // or a delay depth outside the supported range.
  if (H_TOTAL > 65535 || V_TOTAL > 65535 || H_TOTAL < 1 || V_TOTAL < 1 ||
      PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_param_check
    $error("lcd_timing_gen: timing totals must be 1..65535 and PIPE_DLY 0..4");
  end

  logic [15:0] r_pixel_count;
  logic [15:0] r_line_count;
  logic        r_frame_start;
  logic [7:0]  r_frame_count;
  logic        w_pixel_wrap;
  logic        w_rollover;
  logic [2:0]  w_raw;      // {de, hs, vs}, active-high, from the counts
  logic [2:0]  w_dly_out;  // same bundle after the delay line

  assign w_pixel_wrap = (r_pixel_count == H_LAST);
  assign w_rollover   = w_pixel_wrap && (r_line_count == V_LAST);

  // Pixel/line counters: pixel wraps every line, line wraps every frame.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_pixel_count <= 16'd0;
      r_line_count  <= 16'd0;
    end else if (w_pixel_wrap) begin
      r_pixel_count <= 16'd0;
      r_line_count  <= (r_line_count == V_LAST) ? 16'd0 : r_line_count + 16'd1;
    end else begin
      r_pixel_count <= r_pixel_count + 16'd1;
    end
  end

  // Frame strobe and counter change on the edge that lands on (0,0); the
  // (0,0) seen straight out of reset is not a rollover.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_frame_start <= w_rollover;
      if (w_rollover) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Undelayed decodes from the registered counts.
  always_comb begin
    w_raw    = 3'b000;
    w_raw[1] = (r_pixel_count < H_SYNC_END);
    w_raw[0] = (r_line_count < V_SYNC_END);
    w_raw[2] = (r_pixel_count >= H_DE_BEG) && (r_pixel_count < H_DE_END) &&
               (r_line_count >= V_DE_BEG) && (r_line_count < V_DE_END);
  end

  if (PIPE_DLY == 0) begin : g_no_dly
    // Combinational path: force the inactive level while reset is held so
    // the panel never sees a sync pulse out of a held (0,0).
    assign w_dly_out = w_raw & {3{nRST}};
  end else begin : g_dly
    logic [2:0] r_dly [PIPE_DLY];

    // Shift register carrying {de, hs, vs}; every stage resets inactive.
    always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          r_dly[i] <= 3'b000;
        end
      end else begin
        r_dly[0] <= w_raw;
        for (int i = 1; i < PIPE_DLY; i++) begin
          r_dly[i] <= r_dly[i-1];
        end
      end
    end

    assign w_dly_out = r_dly[PIPE_DLY-1];
  end

  // Polarity is applied after the delay so reset stages read inactive.
  assign LCD_DE     = w_dly_out[2];
  assign LCD_HSYNC  = ~(w_dly_out[1] ^ HS_POL);
  assign LCD_VSYNC  = ~(w_dly_out[0] ^ VS_POL);
  assign PixelCount = r_pixel_count;
  assign LineCount  = r_line_count;
  assign FrameStart = r_frame_start;
  assign FrameCount = r_frame_count;

endmodule
